// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite word-addressed SRAM slave with programmable wait states and pipelined transfers.
// Define AHB_LITE_ERR_RESP_EN to answer out-of-range addresses with a two-cycle ERROR response.
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sel,
    input  logic                  write,
    input  logic [1:0]            trans,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ready,
    output logic                  readyout,
    output logic                  resp,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0]    WAIT_LOAD   = WAIT_STATES[CNT_W-1:0];
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = DEPTH[ADDR_WIDTH:0];
    localparam logic [1:0]          TRANS_NONSEQ = 2'b10;
    localparam logic [1:0]          TRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        wait_cnt;
    logic [CNT_W-1:0]        wait_cnt_next;

    // Data-phase context captured from the accepted address phase.
    logic                    dp_valid;
    logic                    dp_write;
    logic                    dp_oor;
    logic [IDX_W-1:0]        dp_idx;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    addr_oor;
    logic                    err_path;
    logic                    completing;

    assign readyout = (state == S_IDLE) || (state == S_ERR2);
    assign accept   = sel && ((trans == TRANS_NONSEQ) || (trans == TRANS_SEQ)) && ready && readyout;
    assign addr_oor = {1'b0, addr} >= DEPTH_LIMIT;

    // A data phase completes with OKAY only in IDLE; out-of-range ones never touch storage.
    assign completing = (state == S_IDLE) && dp_valid && !dp_oor;

`ifdef AHB_LITE_ERR_RESP_EN
    assign err_path = addr_oor;
    assign resp     = (state == S_ERR1) || (state == S_ERR2);
`else
    assign err_path = 1'b0;
    assign resp     = 1'b0;
`endif

    assign rdata = (completing && !dp_write) ? mem[dp_idx] : '0;

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            S_IDLE, S_ERR2: begin
                state_next = S_IDLE;
                if (accept) begin
                    wait_cnt_next = WAIT_LOAD;
                    if (err_path) begin
                        state_next = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_next = wait_cnt - 1'b1;
                if (wait_cnt_next == '0) begin
                    state_next = S_IDLE;
                end
            end
            S_ERR1: begin
                state_next = S_ERR2;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_oor   <= 1'b0;
            dp_idx   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (readyout) begin
                dp_valid <= accept;
                dp_write <= write;
                dp_oor   <= addr_oor;
                dp_idx   <= addr[IDX_W-1:0];
            end
        end
    end

    // NOTE: storage is deliberately cleared by reset, so it is built from flops rather than an SRAM macro.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (completing && dp_write) begin
            mem[dp_idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: three instances with WAIT_STATES of 0, 2 and 3 share one bus.
// Out-of-range expectations follow whether AHB_LITE_ERR_RESP_EN is defined for the build.
module tb_ahb_lite_sram_slave;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       sel     = 1'b0;
    logic       write   = 1'b0;
    logic [1:0] trans   = T_IDLE;
    logic [7:0] addr    = 8'h00;
    logic [7:0] wdata   = 8'h00;

    logic       ry0, rs0, ry2, rs2, ry3, rs3;
    logic [7:0] rd0, rd2, rd3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ahb_lite_sram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset_n(reset_n), .sel(sel), .write(write), .trans(trans),
        .addr(addr), .wdata(wdata), .ready(ry0), .readyout(ry0), .resp(rs0), .rdata(rd0)
    );

    ahb_lite_sram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(16), .WAIT_STATES(2)) u_ws2 (
        .clock(clock), .reset_n(reset_n), .sel(sel), .write(write), .trans(trans),
        .addr(addr), .wdata(wdata), .ready(ry2), .readyout(ry2), .resp(rs2), .rdata(rd2)
    );

    ahb_lite_sram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset_n(reset_n), .sel(sel), .write(write), .trans(trans),
        .addr(addr), .wdata(wdata), .ready(ry3), .readyout(ry3), .resp(rs3), .rdata(rd3)
    );

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        sel   = 1'b0;
        trans = T_IDLE;
        write = 1'b0;
        addr  = 8'h00;
    endtask

    task automatic addr_phase(input logic w, input logic [7:0] a);
        sel   = 1'b1;
        trans = T_NONSEQ;
        write = w;
        addr  = a;
    endtask

    task automatic apply_reset();
        idle_bus();
        reset_n = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_bus();
        reset_n = 1'b0;
        cycle();
        checks++; if (ry0 !== 1'b1) begin errors++; $display("FAIL rst_ready_ws0 got %0b want 1", ry0); end
        checks++; if (ry2 !== 1'b1) begin errors++; $display("FAIL rst_ready_ws2 got %0b want 1", ry2); end
        checks++; if (ry3 !== 1'b1) begin errors++; $display("FAIL rst_ready_ws3 got %0b want 1", ry3); end
        checks++; if (rs0 !== 1'b0) begin errors++; $display("FAIL rst_resp_ws0 got %0b want 0", rs0); end
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL rst_rdata_ws0 got %02h want 00", rd0); end
        checks++; if (rd3 !== 8'h00) begin errors++; $display("FAIL rst_rdata_ws3 got %02h want 00", rd3); end
        cycle();
        reset_n = 1'b1;
        cycle();
        checks++; if (ry0 !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %0b want 1", ry0); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        addr_phase(1'b1, 8'd3);
        cycle();
        checks++; if (ry0 !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready got %0b want 1", ry0); end
        checks++; if (rs0 !== 1'b0) begin errors++; $display("FAIL b2b_wr_resp got %0b want 0", rs0); end
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL b2b_wr_rdata got %02h want 00", rd0); end
        wdata = 8'hA5;
        addr_phase(1'b0, 8'd3);
        cycle();
        checks++; if (ry0 !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready got %0b want 1", ry0); end
        checks++; if (rd0 !== 8'hA5) begin errors++; $display("FAIL b2b_rd_rdata got %02h want a5", rd0); end
        checks++; if (rs0 !== 1'b0) begin errors++; $display("FAIL b2b_rd_resp got %0b want 0", rs0); end
        idle_bus();
        cycle();
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL b2b_idle_rdata got %02h want 00", rd0); end
        // Reset must clear the word just written.
        apply_reset();
        addr_phase(1'b0, 8'd3);
        cycle();
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL mem_reset_rdata got %02h want 00", rd0); end
        idle_bus();
        cycle();
    endtask

    task automatic test_wait_states();
        apply_reset();
        addr_phase(1'b0, 8'd5);
        cycle();
        checks++; if (ry2 !== 1'b0) begin errors++; $display("FAIL ws2_rd_w1 got %0b want 0", ry2); end
        idle_bus();
        cycle();
        checks++; if (ry2 !== 1'b0) begin errors++; $display("FAIL ws2_rd_w2 got %0b want 0", ry2); end
        cycle();
        checks++; if (ry2 !== 1'b1) begin errors++; $display("FAIL ws2_rd_done got %0b want 1", ry2); end
        checks++; if (rd2 !== 8'h00) begin errors++; $display("FAIL ws2_rd_rdata got %02h want 00", rd2); end
        checks++; if (rs2 !== 1'b0) begin errors++; $display("FAIL ws2_rd_resp got %0b want 0", rs2); end
        addr_phase(1'b1, 8'd5);
        cycle();
        checks++; if (ry2 !== 1'b0) begin errors++; $display("FAIL ws2_wr_w1 got %0b want 0", ry2); end
        wdata = 8'h5A;
        idle_bus();
        cycle();
        checks++; if (ry2 !== 1'b0) begin errors++; $display("FAIL ws2_wr_w2 got %0b want 0", ry2); end
        // Presented while readyout=0: must be ignored.
        addr_phase(1'b1, 8'd6);
        cycle();
        checks++; if (ry2 !== 1'b1) begin errors++; $display("FAIL ws2_wr_done got %0b want 1", ry2); end
        addr_phase(1'b0, 8'd5);
        cycle();
        checks++; if (ry2 !== 1'b0) begin errors++; $display("FAIL ws2_rd2_w1 got %0b want 0", ry2); end
        checks++; if (rd2 !== 8'h00) begin errors++; $display("FAIL ws2_rd2_wait_rdata got %02h want 00", rd2); end
        idle_bus();
        cycle();
        checks++; if (ry2 !== 1'b0) begin errors++; $display("FAIL ws2_rd2_w2 got %0b want 0", ry2); end
        cycle();
        checks++; if (ry2 !== 1'b1) begin errors++; $display("FAIL ws2_rd2_done got %0b want 1", ry2); end
        checks++; if (rd2 !== 8'h5A) begin errors++; $display("FAIL ws2_rd2_rdata got %02h want 5a", rd2); end
        cycle();
        checks++; if (ry2 !== 1'b1) begin errors++; $display("FAIL ws2_ignored_phase got %0b want 1", ry2); end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        addr_phase(1'b1, 8'd20);
        cycle();
`ifdef AHB_LITE_ERR_RESP_EN
        checks++; if (ry0 !== 1'b0) begin errors++; $display("FAIL oor_err1_ready got %0b want 0", ry0); end
        checks++; if (rs0 !== 1'b1) begin errors++; $display("FAIL oor_err1_resp got %0b want 1", rs0); end
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL oor_err1_rdata got %02h want 00", rd0); end
        wdata = 8'h3C;
        idle_bus();
        cycle();
        checks++; if (ry0 !== 1'b1) begin errors++; $display("FAIL oor_err2_ready got %0b want 1", ry0); end
        checks++; if (rs0 !== 1'b1) begin errors++; $display("FAIL oor_err2_resp got %0b want 1", rs0); end
        addr_phase(1'b0, 8'd4);
        cycle();
        checks++; if (ry0 !== 1'b1) begin errors++; $display("FAIL oor_rd4_ready got %0b want 1", ry0); end
        checks++; if (rs0 !== 1'b0) begin errors++; $display("FAIL oor_rd4_resp got %0b want 0", rs0); end
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL oor_rd4_rdata got %02h want 00", rd0); end
`else
        checks++; if (ry0 !== 1'b1) begin errors++; $display("FAIL oor_wr_ready got %0b want 1", ry0); end
        checks++; if (rs0 !== 1'b0) begin errors++; $display("FAIL oor_wr_resp got %0b want 0", rs0); end
        wdata = 8'h3C;
        addr_phase(1'b0, 8'd4);
        cycle();
        checks++; if (ry0 !== 1'b1) begin errors++; $display("FAIL oor_rd4_ready got %0b want 1", ry0); end
        checks++; if (rs0 !== 1'b0) begin errors++; $display("FAIL oor_rd4_resp got %0b want 0", rs0); end
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL oor_rd4_rdata got %02h want 00", rd0); end
        addr_phase(1'b0, 8'd20);
        cycle();
        checks++; if (ry0 !== 1'b1) begin errors++; $display("FAIL oor_rd20_ready got %0b want 1", ry0); end
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL oor_rd20_rdata got %02h want 00", rd0); end
        checks++; if (rs0 !== 1'b0) begin errors++; $display("FAIL oor_rd20_resp got %0b want 0", rs0); end
`endif
        idle_bus();
        cycle();
    endtask

    task automatic test_reset_mid_transfer();
        apply_reset();
        addr_phase(1'b1, 8'd1);
        cycle();
        checks++; if (ry3 !== 1'b0) begin errors++; $display("FAIL rmid_w1 got %0b want 0", ry3); end
        wdata = 8'hFF;
        idle_bus();
        cycle();
        checks++; if (ry3 !== 1'b0) begin errors++; $display("FAIL rmid_w2 got %0b want 0", ry3); end
        reset_n = 1'b0;
        #1;
        checks++; if (ry3 !== 1'b1) begin errors++; $display("FAIL rmid_async_ready got %0b want 1", ry3); end
        checks++; if (rd3 !== 8'h00) begin errors++; $display("FAIL rmid_async_rdata got %02h want 00", rd3); end
        cycle();
        reset_n = 1'b1;
        addr_phase(1'b0, 8'd1);
        cycle();
        checks++; if (ry3 !== 1'b0) begin errors++; $display("FAIL rmid_first_accept got %0b want 0", ry3); end
        idle_bus();
        cycle();
        cycle();
        checks++; if (ry3 !== 1'b0) begin errors++; $display("FAIL rmid_rd_w3 got %0b want 0", ry3); end
        cycle();
        checks++; if (ry3 !== 1'b1) begin errors++; $display("FAIL rmid_rd_done got %0b want 1", ry3); end
        checks++; if (rd3 !== 8'h00) begin errors++; $display("FAIL rmid_rd_rdata got %02h want 00", rd3); end
        cycle();
    endtask

    task automatic test_idle_busy();
        logic [7:0] rd_addr [5];
        logic [7:0] rd_exp  [5];
        rd_addr = '{8'd0, 8'd1, 8'd5, 8'd6, 8'd7};
        rd_exp  = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
        apply_reset();
        addr_phase(1'b1, 8'd0);
        cycle();
        wdata = 8'h11;
        sel = 1'b1; trans = T_IDLE; write = 1'b1; addr = 8'd5;
        cycle();
        checks++; if (ry0 !== 1'b1) begin errors++; $display("FAIL ib_idle_ready got %0b want 1", ry0); end
        sel = 1'b1; trans = T_BUSY; write = 1'b1; addr = 8'd6;
        cycle();
        checks++; if (ry0 !== 1'b1 || rs0 !== 1'b0) begin errors++; $display("FAIL ib_busy_ready_resp got %0b/%0b want 1/0", ry0, rs0); end
        sel = 1'b0; trans = T_NONSEQ; write = 1'b1; addr = 8'd7;
        cycle();
        checks++; if (ry0 !== 1'b1 || rs0 !== 1'b0) begin errors++; $display("FAIL ib_nosel_ready_resp got %0b/%0b want 1/0", ry0, rs0); end
        addr_phase(1'b1, 8'd1);
        trans = T_SEQ;
        cycle();
        wdata = 8'h22;
        addr_phase(1'b0, rd_addr[0]);
        cycle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rd0 !== rd_exp[i] || ry0 !== 1'b1) begin
                errors++;
                $display("FAIL ib_read_%0d got %02h/%0b want %02h/1", rd_addr[i], rd0, ry0, rd_exp[i]);
            end
            if (i < 4) addr_phase(1'b0, rd_addr[i+1]);
            else       idle_bus();
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_out_of_range();
        test_reset_mid_transfer();
        test_idle_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
